imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 55 +++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one instruction memory port between fetch and debug,
// with a starvation guard for debug and an exclusive debug lock mode.
module imem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_valid,
  input  logic [31:0] mem_rd_data
);
  typedef enum logic {NORMAL, DBG_OWN} state_t;
  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  state_t     state, state_nx;
  logic [3:0] wait_cnt, wait_nx;
  logic [1:0] owner;
  logic       owned;
  // dropping the lock releases ownership in the same cycle
  assign owned = (state == DBG_OWN) && dbg_lock;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= NORMAL;
    else     state <= state_nx;
  always_comb begin
    state_nx = (dbg_lock && (owned || dbg_gnt)) ? DBG_OWN : NORMAL;
  end
  always_comb begin
    dbg_gnt   = dbg_req && (owned || !if_req || wait_cnt == WMAX);
    if_gnt    = if_req && !owned && !dbg_gnt;
    mem_valid = if_gnt || dbg_gnt;
    mem_addr  = dbg_gnt ? dbg_addr : if_gnt ? if_addr : '0;
  end
  assign wait_nx = (dbg_req && !dbg_gnt) ? ((wait_cnt == WMAX) ? WMAX : wait_cnt + 4'd1) : 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_cnt <= '0;
    else     wait_cnt <= wait_nx;
  // owner tag {dbg, fetch}: which requester the returning read data belongs to
  always_ff @(posedge clk or posedge rst)
    if (rst) owner <= '0;
    else     owner <= {dbg_gnt, if_gnt};
  assign if_rvalid  = owner[0];
  assign dbg_rvalid = owner[1];
  assign if_rdata   = mem_rd_data;
  assign dbg_rdata  = mem_rd_data;
endmodule
